// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for mem_ctrl: FSM state encodings, byte-counter width,
// fetch length and the little-endian instruction assembly helper.
package mem_ctrl_pkg;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] FETCH_LEN = 3'd4;

  typedef enum logic [1:0] {
    MEMCTRL_IDLE    = 2'd0,
    MEMCTRL_FETCH   = 2'd1,
    MEMCTRL_MEM_OWN = 2'd2
  } state_t;

  function automatic logic [31:0] pack_inst(input logic [7:0] b3, input logic [7:0] b2,
                                            input logic [7:0] b1, input logic [7:0] b0);
    return {b3, b2, b1, b0};
  endfunction

endpackage

// File: rtl/mem_ctrl_prefetch_buf.sv
// One-word prefetch buffer (tag + data) for mem_ctrl; compiled only when
// PREFETCH_EN is defined.
`ifdef PREFETCH_EN
module prefetch_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr,
  input  logic        i_inv,
  input  logic [31:0] i_tag,
  input  logic [31:0] i_data,
  input  logic [31:0] i_pc,
  output logic        o_hit,
  output logic [31:0] o_data
);

  logic        r_valid;
  logic [31:0] r_tag;
  logic [31:0] r_data;

  // Invalidation beats a same-cycle fill so a store can never leave stale code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= 32'h0000_0000;
      r_data  <= 32'h0000_0000;
    end else if (i_inv) begin
      r_valid <= 1'b0;
    end else if (i_wr) begin
      r_valid <= 1'b1;
      r_tag   <= i_tag;
      r_data  <= i_data;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_hit  = r_valid && (i_pc == r_tag);
  assign o_data = r_data;

endmodule
`endif

// File: rtl/mem_ctrl.sv
// Byte-wide RAM arbiter between the instruction fetch (4 serial byte reads)
// and the MEM stage, which always has priority. Optional macro: PREFETCH_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_pc_i,
  input  logic              flush_i,
  output logic [31:0]       if_inst_o,
  output logic              if_valid_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [7:0]        mem_wdata_i,
  output logic [7:0]        mem_rdata_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [7:0]        ram_wdata_o,
  input  logic [7:0]        ram_rdata_i,
  output logic              busy_o
);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [31:0]       r_fetch_pc, w_fetch_pc_nxt;
  logic [7:0]        r_b0, r_b1, r_b2;
  logic [31:0]       r_inst, w_inst_nxt;
  logic              r_valid, w_valid_nxt;
  logic              w_clear;
  logic              w_capture;
  logic [31:0]       w_fetch_addr;
  logic [31:0]       w_fetch_word;
  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_we;
  logic [7:0]        w_ram_wdata;

  assign w_fetch_addr = r_fetch_pc + 32'(r_cnt);
  // Byte 3 is taken straight off the RAM bus in the final counter cycle.
  assign w_fetch_word = pack_inst(ram_rdata_i, r_b2, r_b1, r_b0);

`ifdef PREFETCH_EN
  logic        r_spec, w_spec_nxt;
  logic        r_pf_pend, w_pf_pend_nxt;
  logic        w_hit;
  logic        w_buf_wr;
  logic        w_buf_inv;
  logic [31:0] w_buf_data;

  assign w_buf_inv = flush_i | (mem_req_i & mem_we_i);

  prefetch_buf u_prefetch_buf (
    .clk    (clk),
    .rst    (rst),
    .i_wr   (w_buf_wr),
    .i_inv  (w_buf_inv),
    .i_tag  (r_fetch_pc),
    .i_data (w_fetch_word),
    .i_pc   (if_pc_i),
    .o_hit  (w_hit),
    .o_data (w_buf_data)
  );
`endif

  // Next-state, counter and fetch-result logic; a MEM request overrides everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_fetch_pc_nxt = r_fetch_pc;
    w_inst_nxt     = r_inst;
    w_valid_nxt    = 1'b0;
    w_clear        = 1'b0;
    w_capture      = 1'b0;
`ifdef PREFETCH_EN
    w_spec_nxt     = r_spec;
    w_pf_pend_nxt  = r_pf_pend;
    w_buf_wr       = 1'b0;
`endif
    if (mem_req_i) begin
      w_state_nxt = MEMCTRL_MEM_OWN;
      w_cnt_nxt   = '0;
      w_clear     = 1'b1;
`ifdef PREFETCH_EN
      w_spec_nxt    = 1'b0;
      w_pf_pend_nxt = 1'b0;
`endif
    end else begin
      case (r_state)
        MEMCTRL_IDLE: begin
          if (if_req_i && !flush_i && !r_valid) begin
`ifdef PREFETCH_EN
            w_pf_pend_nxt  = 1'b0;
            w_fetch_pc_nxt = if_pc_i;
            if (w_hit) begin
              w_inst_nxt    = w_buf_data;
              w_valid_nxt   = 1'b1;
              w_pf_pend_nxt = 1'b1;
            end else begin
              w_state_nxt = MEMCTRL_FETCH;
              w_cnt_nxt   = '0;
              w_spec_nxt  = 1'b0;
            end
`else
            w_state_nxt    = MEMCTRL_FETCH;
            w_cnt_nxt      = '0;
            w_fetch_pc_nxt = if_pc_i;
`endif
          end
`ifdef PREFETCH_EN
          else if (r_pf_pend && !if_req_i && !flush_i) begin
            w_state_nxt    = MEMCTRL_FETCH;
            w_cnt_nxt      = '0;
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            w_spec_nxt     = 1'b1;
            w_pf_pend_nxt  = 1'b0;
          end
`endif
          else begin
            w_cnt_nxt = '0;
`ifdef PREFETCH_EN
            w_pf_pend_nxt = r_pf_pend & ~flush_i;
`endif
          end
        end
        MEMCTRL_FETCH: begin
          if (flush_i) begin
            w_state_nxt = MEMCTRL_IDLE;
            w_cnt_nxt   = '0;
            w_clear     = 1'b1;
`ifdef PREFETCH_EN
            w_spec_nxt    = 1'b0;
            w_pf_pend_nxt = 1'b0;
`endif
          end
`ifdef PREFETCH_EN
          else if (r_spec && if_req_i) begin
            w_state_nxt = MEMCTRL_IDLE;
            w_cnt_nxt   = '0;
            w_clear     = 1'b1;
            w_spec_nxt  = 1'b0;
          end
`endif
          else if (r_cnt == FETCH_LEN) begin
            w_state_nxt = MEMCTRL_IDLE;
            w_cnt_nxt   = '0;
`ifdef PREFETCH_EN
            if (r_spec) begin
              w_buf_wr   = 1'b1;
              w_spec_nxt = 1'b0;
            end else begin
              w_inst_nxt    = w_fetch_word;
              w_valid_nxt   = 1'b1;
              w_pf_pend_nxt = 1'b1;
            end
`else
            w_inst_nxt  = w_fetch_word;
            w_valid_nxt = 1'b1;
`endif
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
            w_capture = (r_cnt != 3'd0);
          end
        end
        MEMCTRL_MEM_OWN: begin
          w_state_nxt = MEMCTRL_IDLE;
          w_cnt_nxt   = '0;
        end
        default: begin
          w_state_nxt = MEMCTRL_IDLE;
          w_cnt_nxt   = '0;
          w_clear     = 1'b1;
        end
      endcase
    end
  end

  // State, counter, captured bytes and registered fetch result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= MEMCTRL_IDLE;
      r_cnt      <= '0;
      r_fetch_pc <= 32'h0000_0000;
      r_b0       <= 8'h00;
      r_b1       <= 8'h00;
      r_b2       <= 8'h00;
      r_inst     <= 32'h0000_0000;
      r_valid    <= 1'b0;
`ifdef PREFETCH_EN
      r_spec     <= 1'b0;
      r_pf_pend  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_inst     <= w_inst_nxt;
      r_valid    <= w_valid_nxt;
`ifdef PREFETCH_EN
      r_spec     <= w_spec_nxt;
      r_pf_pend  <= w_pf_pend_nxt;
`endif
      if (w_clear) begin
        r_b0 <= 8'h00;
        r_b1 <= 8'h00;
        r_b2 <= 8'h00;
      end else if (w_capture) begin
        case (r_cnt)
          3'd1:    r_b0 <= ram_rdata_i;
          3'd2:    r_b1 <= ram_rdata_i;
          3'd3:    r_b2 <= ram_rdata_i;
          default: r_b0 <= r_b0;
        endcase
      end else begin
        r_b0 <= r_b0;
      end
    end
  end

  // RAM port mux: reset silences the port, MEM wins over the fetch sequencer.
  always_comb begin
    w_ram_addr  = '0;
    w_ram_we    = 1'b0;
    w_ram_wdata = 8'h00;
    if (rst) begin
      w_ram_we = 1'b0;
    end else if (mem_req_i) begin
      w_ram_addr  = ADDR_W'(mem_addr_i);
      w_ram_we    = mem_we_i;
      w_ram_wdata = mem_wdata_i;
    end else if (r_state == MEMCTRL_FETCH) begin
      w_ram_addr = ADDR_W'(w_fetch_addr);
    end else begin
      w_ram_we = 1'b0;
    end
  end

  assign ram_addr_o  = w_ram_addr;
  assign ram_we_o    = w_ram_we;
  assign ram_wdata_o = w_ram_wdata;
  assign mem_rdata_o = ram_rdata_i;
  assign if_inst_o   = r_inst;
  assign if_valid_o  = r_valid;
  assign busy_o      = (r_state != MEMCTRL_IDLE);

endmodule
